mips_div_sequencer: RTL and testbench
=====================================

MIPS_DIV_SEQUENCER -- requirements
Module: mips_div_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 is_signed  input  1  1=DIV, 0=DIVU; sampled with start.
REQ-006 abort  input  1  flush in-flight operation.
REQ-007 operand_a  input  DATA_WIDTH  dividend (rs); sampled with start.
REQ-008 operand_b  input  DATA_WIDTH  divisor (rt); sampled with start.
REQ-009 busy  output  1  high in every state except IDLE; drives pipeline stall.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 div_lo  output  DATA_WIDTH  quotient; feeds LO register input.
REQ-012 div_hi  output  DATA_WIDTH  remainder; feeds HI register input.
REQ-013 hi_write, lo_write  output  1 each  equal to done.
REQ-014 div_by_zero  output  1  high with done when divisor was zero.

Function
REQ-015 FSM states: IDLE, PREP, ITER, FIX, DONE.
REQ-016 IDLE: start=1 and abort=0 -> PREP; operands and sign mode latched on that edge.
REQ-017 PREP: magnitudes formed (abs values if signed); result sign and remainder sign recorded; counter cleared -> ITER.
REQ-018 ITER: one restoring shift-subtract step per cycle; counter increments; after DATA_WIDTH steps -> FIX.
REQ-019 FIX: quotient negated if operand signs differ (signed); remainder takes dividend sign (signed) -> DONE.
REQ-020 DONE: done, hi_write, lo_write pulse for exactly one cycle -> IDLE.
REQ-021 Latency fixed: done asserted DATA_WIDTH+2 edges after the edge that sampled start (34 for default).
REQ-022 div_lo/div_hi hold the last completed result until the next DONE; stable while busy.
REQ-023 start while busy is ignored; no queuing.
REQ-024 abort in any non-IDLE state -> IDLE on next edge; no done, no hi/lo write, outputs keep prior result.
REQ-025 abort and start same cycle in IDLE: abort wins, stays IDLE.
REQ-026 Divisor zero: full latency; quotient all ones, remainder = original dividend, div_by_zero=1 with done.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no flag.
REQ-028 Arithmetic: internal partial remainder DATA_WIDTH+1 bits; magnitudes unsigned DATA_WIDTH bits.

Reset
REQ-029 rst high: state=IDLE, counter=0, busy=0, done=0, hi_write=lo_write=0, div_by_zero=0, div_lo=div_hi=0, immediately and asynchronously.
REQ-030 rst mid-operation discards the operation; no write pulse on release.

Configuration
REQ-031 Macro DIV_SIGNED_EN defined: is_signed honoured per REQ-017/019/027.
REQ-032 DIV_SIGNED_EN undefined: is_signed ignored, all operations unsigned, sign-fix logic removed; latency unchanged.

Structure
REQ-033 div_state_t enum and DIV_CNT_WIDTH constant live in mips_pkg.
REQ-034 One combinational sub-module div_step: one restoring step (partial remainder, quotient bit).
REQ-035 Instantiated in datapath in place of the tied-off div_hi/div_lo; busy ORed into controller stall.

Verification
REQ-036 Unsigned 100/7 -> done at edge 34, div_lo=14, div_hi=2, hi_write=lo_write=1 one cycle.
REQ-037 Signed -7/2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF; unsigned build -> div_lo=0x7FFFFFFC, div_hi=0x1.
REQ-038 5/0 -> div_lo=0xFFFFFFFF, div_hi=5, div_by_zero=1 with done.
REQ-039 Signed 0x80000000/0xFFFFFFFF -> div_lo=0x80000000, div_hi=0.
REQ-040 Start 100/7, abort at edge 10 -> busy low at edge 11, no done, outputs keep previous result; second start during busy ignored.
REQ-041 rst asserted at edge 20 of an operation -> outputs 0 without clock edge, no done after release.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS integer divide sequencer.
//   div_state_t   : divider FSM state encoding
//   DIV_CNT_WIDTH : width of the iteration counter (covers DATA_WIDTH up to 64)
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  localparam int DIV_CNT_WIDTH = 6;

endpackage : mips_pkg

// File: rtl/mips_div_sequencer_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring shift-subtract step of an unsigned divider.
// Ports:
//   rem_in       : partial remainder before the step (DATA_WIDTH+1 bits)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : unsigned divisor magnitude
//   rem_out      : partial remainder after the step
//   q_bit        : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in[DATA_WIDTH-1:0], dividend_bit};
    diff    = shifted - {1'b0, divisor};
    // A set top bit of rem_in means the shifted value overflows the window
    // and is certainly >= divisor; otherwise the borrow bit decides.
    q_bit   = rem_in[DATA_WIDTH] | ~diff[DATA_WIDTH];
    rem_out = q_bit ? diff : shifted;
  end

endmodule : div_step

// File: rtl/mips_div_sequencer.sv
// -----------------------------------------------------------------------------
// mips_div_sequencer
// Multi-cycle restoring divider for MIPS DIV/DIVU. Fixed latency: done pulses
// DATA_WIDTH+2 edges after the edge that samples start.
// Configuration macro: DIV_SIGNED_EN -- when defined, is_signed selects DIV
// (signed) semantics; when undefined all operations are unsigned and the
// sign-fix logic is absent.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start, is_signed      : request (sampled in IDLE) and DIV/DIVU select
//   abort                 : flush the in-flight operation
//   operand_a, operand_b  : dividend (rs) and divisor (rt)
//   busy                  : high in every non-IDLE state (pipeline stall)
//   done                  : one-cycle completion pulse
//   div_lo, div_hi        : quotient / remainder of the last completed op
//   hi_write, lo_write    : HI/LO write enables, equal to done
//   div_by_zero           : high with done when the divisor was zero
// -----------------------------------------------------------------------------
module mips_div_sequencer
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] div_lo,
  output logic [DATA_WIDTH-1:0] div_hi,
  output logic                  hi_write,
  output logic                  lo_write,
  output logic                  div_by_zero
);

  localparam logic [DIV_CNT_WIDTH-1:0] LAST_STEP = DIV_CNT_WIDTH'(DATA_WIDTH - 1);

  div_state_t               state_q, state_d;
  logic [DIV_CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0]    a_q,     a_d;     // original dividend
  logic [DATA_WIDTH-1:0]    b_q,     b_d;     // divisor, magnitude after PREP
  logic [DATA_WIDTH-1:0]    quo_q,   quo_d;   // dividend bits out, quotient bits in
  logic [DATA_WIDTH:0]      rem_q,   rem_d;   // partial remainder
  logic [DATA_WIDTH-1:0]    lo_q,    lo_d;
  logic [DATA_WIDTH-1:0]    hi_q,    hi_d;
  logic                     dbz_q,   dbz_d;

`ifdef DIV_SIGNED_EN
  logic sgn_q,   sgn_d;
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
`endif

  logic [DATA_WIDTH:0] step_rem;
  logic                step_q_bit;

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_step (
    .rem_in      (rem_q),
    .dividend_bit(quo_q[DATA_WIDTH-1]),
    .divisor     (b_q),
    .rem_out     (step_rem),
    .q_bit       (step_q_bit)
  );

  // NOTE: every _d gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
`endif

    unique case (state_q)
      DIV_IDLE: begin
        if (start && !abort) begin
          state_d = DIV_PREP;
          a_d     = operand_a;
          b_d     = operand_b;
`ifdef DIV_SIGNED_EN
          sgn_d   = is_signed;
`endif
        end
      end

      DIV_PREP: begin
        state_d = DIV_ITER;
        cnt_d   = '0;
        rem_d   = '0;
`ifdef DIV_SIGNED_EN
        q_neg_d = sgn_q & (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]);
        r_neg_d = sgn_q & a_q[DATA_WIDTH-1];
        quo_d   = (sgn_q && a_q[DATA_WIDTH-1]) ? -a_q : a_q;
        b_d     = (sgn_q && b_q[DATA_WIDTH-1]) ? -b_q : b_q;
`else
        quo_d   = a_q;
`endif
      end

      DIV_ITER: begin
        quo_d = {quo_q[DATA_WIDTH-2:0], step_q_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + DIV_CNT_WIDTH'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DIV_FIX;
        end
      end

      DIV_FIX: begin
        state_d = DIV_DONE;
        dbz_d   = (b_q == '0);
        if (b_q == '0) begin
          // MIPS-style defined result: all-ones quotient, dividend as remainder.
          lo_d = '1;
          hi_d = a_q;
        end else begin
`ifdef DIV_SIGNED_EN
          lo_d = q_neg_q ? -quo_q : quo_q;
          hi_d = r_neg_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
`else
          lo_d = quo_q;
          hi_d = rem_q[DATA_WIDTH-1:0];
`endif
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // Abort flushes the operation and must leave the visible result untouched.
    if (abort && (state_q != DIV_IDLE)) begin
      state_d = DIV_IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dbz_d   = dbz_q;
    end
  end

  // NOTE: datapath registers are reset too, so outputs read zero under reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
`endif
    end
  end

  assign busy        = (state_q != DIV_IDLE);
  assign done        = (state_q == DIV_DONE);
  assign hi_write    = done;
  assign lo_write    = done;
  assign div_by_zero = done & dbz_q;
  assign div_lo      = lo_q;
  assign div_hi      = hi_q;

endmodule : mips_div_sequencer

// File: tb/tb_mips_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mips_div_sequencer
// Directed vectors for mips_div_sequencer. Stimulus pushes hand-computed
// results into a scoreboard queue; a monitor on the falling edge pops and
// compares whenever done is presented. Expectations follow DIV_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_mips_div_sequencer;

  localparam int W       = 32;
  localparam int LATENCY = W + 2;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           start_edge;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done, hi_write, lo_write, div_by_zero;
  logic [W-1:0] div_lo, div_hi;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  logic prev_done = 1'b0;

  mips_div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .abort      (abort),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .div_lo     (div_lo),
    .div_hi     (div_hi),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_single_cycle", W'(prev_done), W'(0));
        if (sb.size() == 0) begin
          check("unexpected_done", W'(done), W'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("div_lo", div_lo, e.lo);
          check("div_hi", div_hi, e.hi);
          check("div_by_zero", W'(div_by_zero), W'(e.dbz));
          check("hi_write", W'(hi_write), W'(1));
          check("lo_write", W'(lo_write), W'(1));
          check("latency", W'(edge_cnt - e.start_edge), W'(LATENCY));
        end
      end else begin
        check("write_idle", W'({hi_write, lo_write, div_by_zero}), W'(0));
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic expect_done, input logic [W-1:0] elo,
                       input logic [W-1:0] ehi, input logic edbz);
    exp_t e;
    @(posedge clk);
    #2;
    start     = 1'b1;
    is_signed = sgn;
    operand_a = a;
    operand_b = b;
    if (expect_done) begin
      e.lo = elo; e.hi = ehi; e.dbz = edbz; e.start_edge = edge_cnt + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("completion_timeout", W'(n >= 200), W'(0));
  endtask

  initial begin
    // Reset state, asynchronous from time zero
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_lo", div_lo, '0);
    check("rst_hi", div_hi, '0);
    check("rst_dbz", W'(div_by_zero), W'(0));
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Unsigned basic
    issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0);
    wait_idle();
    check("hold_after_done_lo", div_lo, 32'd14);
    // Signed negative dividend
`ifdef DIV_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
`else
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0);
`endif
    wait_idle();
    // DIVU of the same bits in either build
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0);
    wait_idle();
    // Divide by zero, unsigned
    issue(32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    wait_idle();
    // Divide by zero, signed negative dividend
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    wait_idle();
    // Overflow case
`ifdef DIV_SIGNED_EN
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    wait_idle();
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    wait_idle();
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0);
`else
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
    wait_idle();
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0, 32'd7, 1'b0);
    wait_idle();
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'h0, 32'hFFFF_FF9C, 1'b0);
`endif
    wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    wait_idle();

    // Abort mid-operation; a second start while busy is ignored
    issue(32'd100, 32'd7, 1'b0, 1'b0, '0, '0, 1'b0);   // now just after sample edge S
    @(posedge clk); #2 start = 1'b1; operand_a = 32'd3; operand_b = 32'd1;
    @(posedge clk); #2 start = 1'b0;                    // just after S+2
    check("busy_during_op", W'(busy), W'(1));
    repeat (8) @(posedge clk);                          // edge S+10
    #2 abort = 1'b1;
    @(posedge clk);                                     // edge S+11
    #1;
    check("abort_busy_low", W'(busy), W'(0));
    check("abort_keep_lo", div_lo, 32'hFFFF_FFFF);
    check("abort_keep_hi", div_hi, 32'h0);
    #1 abort = 1'b0;
    repeat (45) @(posedge clk);
    #2 check("abort_stays_idle", W'(busy), W'(0));

    // abort and start together in IDLE: abort wins
    @(posedge clk); #2 start = 1'b1; abort = 1'b1; operand_a = 32'd9; operand_b = 32'd3;
    @(posedge clk); #1 check("abort_start_idle", W'(busy), W'(0));
    #1 start = 1'b0; abort = 1'b0;
    repeat (40) @(posedge clk);

    // Reset mid-operation
    issue(32'd100, 32'd7, 1'b0, 1'b0, '0, '0, 1'b0);   // just after sample edge S
    repeat (20) @(posedge clk);                         // edge S+20
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_lo", div_lo, '0);
    check("midrst_hi", div_hi, '0);
    check("midrst_write", W'({hi_write, lo_write, div_by_zero}), W'(0));
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (40) @(posedge clk);
    #2 check("midrst_no_restart", W'(busy), W'(0));

    // Recovery after reset
    issue(32'd1000, 32'd33, 1'b0, 1'b1, 32'd30, 32'd10, 1'b0);
    wait_idle();
    check("scoreboard_drained", W'(sb.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_mips_div_sequencer
